eth_tx_sched: RTL
=================

Name: eth_tx_sched

Overview:
- Single-clock transmit scheduler for the Ethernet TX path.
- Shares the TX frame buffer between two byte-stream requesters using round-robin arbitration.
- Per frame sequence: flush buffer, stream payload, zero-pad to minimum length, start transmission, wait for completion, then hold an inter-frame gap.
- Sits on the HCLK side between requesters and the TX frame memory / command register. tx_done and flush_ack are already synchronous to HCLK.

Parameters:
LW, 8, width of frame length fields.
MIN_LEN, 60, minimum frame bytes; shorter frames are zero-padded.
MAX_LEN, 240, maximum accepted len (buffer capacity after preamble).
GAP_CYCLES, 24, idle cycles after each frame (>=1).
TIMEOUT, 4096, watchdog cycles for FLUSH, LOAD and WAIT (>=2).

Ports:
HCLK  in  1  clock; all logic on rising edge.
HRESET  in  1  synchronous reset, active-high.
req  in  2  per-requester frame request, level.
len  in  2*LW  per-requester byte count; requester k uses bits [k*LW +: LW].
valid  in  2  per-requester data byte valid.
data  in  16  per-requester byte; requester k uses [k*8 +: 8].
ready  out  2  per-requester byte accept, one-hot or zero.
done  out  2  one-cycle pulse: frame transmitted.
err  out  2  one-cycle pulse: frame rejected or timed out.
cmd_flush  out  1  buffer flush request, level.
flush_ack  in  1  buffer flush acknowledge, pulse.
mem_wr  out  1  buffer byte write strobe.
mem_wd  out  8  buffer write data.
cmd_tx  out  1  transmit command, level.
tx_done  in  1  transmitter completion.
busy  out  1  high whenever state != IDLE.
frames  out  16  count of successful frames; wraps 0xFFFF->0.

Behaviour:
- Reset: state=IDLE, last=1 (requester 0 wins first tie). All outputs 0, frames=0, byte count=0, watchdog=0.
- Reset mid-frame: aborts on that same edge, with no done/err pulse.
- States: IDLE, FLUSH, LOAD, PAD, START, WAIT, GAP.
- IDLE: candidates are k with req[k]=1.
  - Both requesting: grant g = ~last. Else grant the single requester.
  - Registered g and len[g] are latched on the transition edge.
  - If len[g]==0 or len[g]>MAX_LEN: err[g] pulses next cycle, last=g, state stays IDLE.
  - Otherwise go to FLUSH.
- FLUSH: cmd_flush=1. On flush_ack=1: cmd_flush=0 and go to LOAD next edge with count=0.
- LOAD: ready[g]=1 (combinational from state and g).
  - Each cycle valid[g]&ready[g]: mem_wr=1, mem_wd=data[g] in the same cycle, count++.
  - When accepting the byte at count==len-1: go to PAD if len<MIN_LEN, else START.
  - valid low stalls without a write.
  - req[g] dropping mid-frame is ignored; the grant holds until done or err.
- PAD: mem_wr=1, mem_wd=0x00 every cycle, count++. The write at count==MIN_LEN-1 is the last; then go to START.
- START: cmd_tx=1 for one cycle, then go to WAIT.
- WAIT: cmd_tx stays 1. On tx_done=1: cmd_tx=0, done[g] pulses, frames++, last=g, go to GAP.
- GAP: all strobes 0 for exactly GAP_CYCLES cycles, then IDLE. A new grant is evaluated in the IDLE cycle after that.
- Watchdog:
  - Clears on entry to FLUSH, LOAD and WAIT, and on every accepted LOAD byte.
  - Increments each cycle in those states.
  - At TIMEOUT-1: err[g] pulses, cmd_flush=0, cmd_tx=0, last=g, go to GAP. frames is unchanged.
- Simultaneous events:
  - flush_ack and timeout in the same cycle: ack wins.
  - tx_done and timeout in the same cycle: tx_done wins.
- Latency: the first byte is accepted no earlier than 2 cycles after grant.
- ready, mem_wr, cmd_flush and cmd_tx are never asserted outside their states. done and err are mutually exclusive per frame.

Test Plan:
- Single req0, len=64: ack FLUSH after 3 cycles, stream 64 bytes 0x00..0x3F, tx_done after 100 cycles -> 64 mem_wr in order, no PAD, cmd_tx high until tx_done, done[0] once, frames=1, GAP 24 cycles.
- req1, len=10, bytes 0xA0..0xA9 -> 10 data writes, then 50 writes of 0x00 (60 total), then cmd_tx; done[1].
- req0 and req1 held continuously after reset -> grants 0,1,0,1 over four frames; ready never asserted to both.
- req0 len=0, then len=241 -> err[0] pulse each time, no cmd_flush, no mem_wr; with req1 also pending, the next grant goes to req1.
- flush_ack withheld -> err pulse at cycle TIMEOUT-1 after FLUSH entry, cmd_flush drops. LOAD with valid stalled 4096 cycles -> err, no cmd_tx, frames unchanged.
- HRESET asserted mid-LOAD (byte 20 of 64) -> next edge: all outputs 0, busy=0, frames=0. The following tie grants req0.

Source files
------------

// File: rtl/eth_tx_sched_if.sv
// Requester, buffer and transmitter signals of the TX scheduler.
// slave is the scheduler's side; master is the side that drives requests.
interface eth_tx_sched_if #(
  parameter int unsigned LW = 8
);
  logic [1:0]      req;
  logic [2*LW-1:0] len;
  logic [1:0]      valid;
  logic [15:0]     data;
  logic [1:0]      ready;
  logic [1:0]      done;
  logic [1:0]      err;
  logic            cmd_flush;
  logic            flush_ack;
  logic            mem_wr;
  logic [7:0]      mem_wd;
  logic            cmd_tx;
  logic            tx_done;
  logic            busy;
  logic [15:0]     frames;

  modport slave (
    input  req, len, valid, data, flush_ack, tx_done,
    output ready, done, err, cmd_flush, mem_wr, mem_wd, cmd_tx, busy, frames
  );

  modport master (
    output req, len, valid, data, flush_ack, tx_done,
    input  ready, done, err, cmd_flush, mem_wr, mem_wd, cmd_tx, busy, frames
  );
endinterface

// File: rtl/eth_tx_sched.sv
// Round-robin TX scheduler: flush, load, zero-pad, transmit and inter-frame gap
// for two byte-stream requesters sharing one frame buffer.
module eth_tx_sched #(
  parameter int unsigned LW         = 8,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 240,
  parameter int unsigned GAP_CYCLES = 24,
  parameter int unsigned TIMEOUT    = 4096
) (
  input logic          HCLK,
  input logic          HRESET,
  eth_tx_sched_if.slave bus
);

  localparam int unsigned WW = $clog2(TIMEOUT);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StFlush, StLoad, StPad, StStart, StWait, StGap
  } state_e;

  state_e          st_q;
  logic            g_q;
  logic            last_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   cnt_q;
  logic [WW-1:0]   wdog_q;
  logic [GW-1:0]   gap_q;
  logic [1:0]      done_q;
  logic [1:0]      err_q;
  logic            cmd_flush_q;
  logic            cmd_tx_q;
  logic [15:0]     frames_q;

  logic            gnt;
  logic [LW-1:0]   req_len;
  logic [7:0]      g_data;
  logic            accept;
  logic            wdog_expired;

  always_comb begin
    gnt          = (&bus.req) ? ~last_q : bus.req[1];
    req_len      = gnt ? bus.len[LW +: LW] : bus.len[0 +: LW];
    g_data       = g_q ? bus.data[15:8] : bus.data[7:0];
    accept       = (st_q == StLoad) && bus.valid[g_q];
    wdog_expired = (wdog_q == WW'(TIMEOUT - 1));
  end

  assign bus.ready     = (st_q == StLoad) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.mem_wr    = accept || (st_q == StPad);
  assign bus.mem_wd    = accept ? g_data : 8'h00;
  assign bus.cmd_flush = cmd_flush_q;
  assign bus.cmd_tx    = cmd_tx_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = (st_q != StIdle);
  assign bus.frames    = frames_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      st_q        <= StIdle;
      g_q         <= 1'b0;
      last_q      <= 1'b1;
      len_q       <= '0;
      cnt_q       <= '0;
      wdog_q      <= '0;
      gap_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      cmd_flush_q <= 1'b0;
      cmd_tx_q    <= 1'b0;
      frames_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      unique case (st_q)
        StIdle: begin
          if (|bus.req) begin
            g_q   <= gnt;
            len_q <= req_len;
            if (req_len == '0 || req_len > LW'(MAX_LEN)) begin
              err_q[gnt] <= 1'b1;
              last_q     <= gnt;
            end else begin
              st_q        <= StFlush;
              cmd_flush_q <= 1'b1;
              wdog_q      <= '0;
            end
          end
        end
        StFlush: begin
          // An acknowledge in the expiry cycle still counts.
          if (bus.flush_ack) begin
            st_q        <= StLoad;
            cmd_flush_q <= 1'b0;
            cnt_q       <= '0;
            wdog_q      <= '0;
          end else if (wdog_expired) begin
            st_q <= StGap; gap_q <= '0; err_q[g_q] <= 1'b1; last_q <= g_q;
            cmd_flush_q <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StLoad: begin
          if (accept) begin
            cnt_q  <= cnt_q + 1'b1;
            wdog_q <= '0;
            if (cnt_q == len_q - 1'b1) begin
              if (len_q < LW'(MIN_LEN)) begin
                st_q <= StPad;
              end else begin
                st_q     <= StStart;
                cmd_tx_q <= 1'b1;
              end
            end
          end else if (wdog_expired) begin
            st_q <= StGap; gap_q <= '0; err_q[g_q] <= 1'b1; last_q <= g_q;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StPad: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LW'(MIN_LEN - 1)) begin
            st_q     <= StStart;
            cmd_tx_q <= 1'b1;
          end
        end
        StStart: begin
          st_q   <= StWait;
          wdog_q <= '0;
        end
        StWait: begin
          // Completion beats a simultaneous watchdog expiry.
          if (bus.tx_done) begin
            st_q <= StGap; gap_q <= '0; done_q[g_q] <= 1'b1; last_q <= g_q;
            cmd_tx_q <= 1'b0;
            frames_q <= frames_q + 1'b1;
          end else if (wdog_expired) begin
            st_q <= StGap; gap_q <= '0; err_q[g_q] <= 1'b1; last_q <= g_q;
            cmd_tx_q <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            st_q <= StIdle;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule
